genesis_pad_scanner: RTL and testbench
======================================

# genesis_pad_scanner

Parametrised multi-port Sega Genesis controller scanner; successor to the single-pad controller interface feeding the CPU `controller` input. One shared select line is time-multiplexed across a frame of select phases, and every port's six data pins are sampled through a synchroniser. Each frame produces a consistent snapshot per pad: 3/6-button detection, presence flags and active-high button vectors, with an optional press/release pulse. Sits between the board pins and the processor/VGA button consumers.

## Interface
- `NUM_PADS`, 2, number of controller ports (1–4)
- `CLK_DIV`, 250, clk cycles per select phase (≥4)
- `FRAME_PHASES`, 256, phases per frame (≥9); phases 8..FRAME_PHASES-1 are idle gap

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `pad_data`  in  6*NUM_PADS  raw active-low pins per pad, pad i at [6i+5:6i] = {pin9, pin6, pin4, pin3, pin2, pin1}
- `select`  out  1  shared select line (pin7 on every port)
- `buttons`  out  12*NUM_PADS  active-high per pad = {Mode, X, Y, Z, Start, C, B, A, Right, Left, Down, Up}
- `present`  out  NUM_PADS  pad detected this frame
- `six_btn`  out  NUM_PADS  pad identified as 6-button
- `frame_done`  out  1  one-cycle pulse when outputs commit
- `pressed`  out  12*NUM_PADS  one-cycle rise pulse per button (macro-dependent)
- `released`  out  12*NUM_PADS  one-cycle fall pulse per button (macro-dependent)

## Operation
- Two-flop synchroniser on all `pad_data` bits; sampling always uses the synchronised value.
- Divider `d` counts 0..CLK_DIV-1; phase `p` counts 0..FRAME_PHASES-1 and increments when `d` wraps, wrapping to 0.
- `select` is registered: 1 when p≥8 or p even; 0 when p odd and p<8.
- Sample point is the cycle with d==CLK_DIV-1. Per-pad shadow capture (inverting active-low pins):
  - p0 (sel=1): Up, Down, Left, Right, B, C from pin1,2,3,4,6,9
  - p1 (sel=0): A=pin6, Start=pin9; shadow present = (pin3==0 && pin4==0)
  - p5 (sel=0): shadow six = (pin1..pin4 all 0)
  - p6 (sel=1): Z=pin1, Y=pin2, X=pin3, Mode=pin4 (captured unconditionally)
  - p2, p3, p4, p7 and gap phases: no capture
- Commit at the p7 sample point: `present`, `six_btn` and `buttons` load from shadow in one edge. Non-present pad: all 12 bits and `six_btn` forced 0. Present but not six: bits [11:8] forced 0.
- Gap phases hold select high (≥1.5 ms at defaults with 25 MHz clk), so 6-button pads reset their internal counters.
- Reset (any time, including mid-frame): d=0, p=0, select=1, synchroniser/shadow/outputs all 0, frame_done=0, pressed/released=0. A partial frame is discarded; no commit occurs until a full p0..p7 sequence completes.

## Timing
- `select` toggles on the edge where `d` wraps; pins then settle for CLK_DIV-1 cycles (2 of them absorbed by the synchroniser) before sampling.
- First `frame_done`: high during the cycle after rising edge 8*CLK_DIV following reset deassertion; the outputs are valid in that same cycle. It then repeats every FRAME_PHASES*CLK_DIV cycles.
- `frame_done` is exactly one cycle wide, and commit outputs are stable for the whole frame.
- Pin-to-output latency: at most one frame plus 8*CLK_DIV cycles.

## Configuration
- `PAD_EDGE_DETECT_EN` defined: at commit, `pressed` = new & ~old and `released` = ~new & old per bit. Both use the post-forcing `buttons` values and pulse in the same cycle as `frame_done`. Pad presence change, 0→1 or 1→0, generates the corresponding edges.
- Undefined: `pressed` and `released` are tied to 0, and no previous-state registers are built. All other behaviour is identical.

## Test plan
- Reset low mid-phase p3 with all pins low, then release → `select`=1 and all outputs 0 immediately; first `frame_done` occurs 8*CLK_DIV cycles after release, not earlier.
- 3-button model on pad0 holding A+Up (p1 pins 3,4 low; p5 pins not all low) → buttons[11:0]=12'h011, present[0]=1, six_btn[0]=0.
- 6-button model on pad1 holding Mode+C (NUM_PADS=2) → buttons[23:12]=12'h840, six_btn[1]=1.
- All pins of pad0 high (unplugged), including Mode-like values in p6 → present[0]=0, buttons[11:0]=0.
- CLK_DIV=4, FRAME_PHASES=9 → `select` sequence 1,0,1,0,1,0,1,0,1 in 4-cycle phases; `frame_done` period 36 cycles.
- With PAD_EDGE_DETECT_EN: Start pressed in frame N, released in frame N+2 → pressed bit7 pulses with frame N's `frame_done` only; released bit7 pulses with frame N+2's only. Without the macro, both stay 0.

Source files
------------

// File: rtl/genesis_pad_scanner.sv
// genesis_pad_scanner: multi-port Sega Genesis pad scanner driving one shared
// select line through a frame of phases and committing one snapshot per pad
// per frame.
// Ports: clk, reset (async, active low), pad_data[6*NUM_PADS] raw active-low
//   pins {pin9,pin6,pin4,pin3,pin2,pin1} per pad, select (pin7, all ports),
//   buttons[12*NUM_PADS] {Mode,X,Y,Z,Start,C,B,A,Right,Left,Down,Up},
//   present, six_btn, frame_done, pressed, released.
// Option macro PAD_EDGE_DETECT_EN: builds press/release pulses at commit;
//   without it pressed/released are tied to 0.
module genesis_pad_scanner #(
  parameter int NUM_PADS     = 2,
  parameter int CLK_DIV      = 250,
  parameter int FRAME_PHASES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6*NUM_PADS-1:0]   pad_data,
  output logic                    select,
  output logic [12*NUM_PADS-1:0]  buttons,
  output logic [NUM_PADS-1:0]     present,
  output logic [NUM_PADS-1:0]     six_btn,
  output logic                    frame_done,
  output logic [12*NUM_PADS-1:0]  pressed,
  output logic [12*NUM_PADS-1:0]  released
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FRAME_PHASES);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(FRAME_PHASES - 1);

  logic [DW-1:0] r_div;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_ph_next;
  logic          w_div_wrap;
  logic          w_sel_next;

  logic [6*NUM_PADS-1:0] r_sync1;
  logic [6*NUM_PADS-1:0] r_sync2;
  logic [6*NUM_PADS-1:0] w_act;

  logic [NUM_PADS-1:0][11:0] r_sh_btn;
  logic [NUM_PADS-1:0]       r_sh_pres;
  logic [NUM_PADS-1:0]       r_sh_six;
  logic [NUM_PADS-1:0][11:0] w_new_btn;
  logic [NUM_PADS-1:0]       w_new_six;

  logic w_cap0, w_cap1, w_cap5, w_cap6, w_commit;

  always_comb begin
    w_div_wrap = (r_div == DIV_LAST);
    w_ph_next  = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
    // select high during gap and even phases of the active window
    w_sel_next = (w_ph_next >= PW'(8)) || !w_ph_next[0];
    w_cap0   = w_div_wrap && (r_phase == PW'(0));
    w_cap1   = w_div_wrap && (r_phase == PW'(1));
    w_cap5   = w_div_wrap && (r_phase == PW'(5));
    w_cap6   = w_div_wrap && (r_phase == PW'(6));
    w_commit = w_div_wrap && (r_phase == PW'(7));
    w_act    = ~r_sync2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div   <= '0;
      r_phase <= '0;
      select  <= 1'b1;
    end else if (w_div_wrap) begin
      r_div   <= '0;
      r_phase <= w_ph_next;
      select  <= w_sel_next;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_btn  <= '0;
      r_sh_pres <= '0;
      r_sh_six  <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        unique case (1'b1)
          w_cap0: begin
            r_sh_btn[i][0] <= w_act[6*i+0];
            r_sh_btn[i][1] <= w_act[6*i+1];
            r_sh_btn[i][2] <= w_act[6*i+2];
            r_sh_btn[i][3] <= w_act[6*i+3];
            r_sh_btn[i][5] <= w_act[6*i+4];
            r_sh_btn[i][6] <= w_act[6*i+5];
          end
          w_cap1: begin
            r_sh_btn[i][4] <= w_act[6*i+4];
            r_sh_btn[i][7] <= w_act[6*i+5];
            // pins 3/4 grounded while select low marks a pad
            r_sh_pres[i]   <= w_act[6*i+2] && w_act[6*i+3];
          end
          w_cap5: begin
            r_sh_six[i] <= &w_act[6*i +: 4];
          end
          w_cap6: begin
            r_sh_btn[i][8]  <= w_act[6*i+0];
            r_sh_btn[i][9]  <= w_act[6*i+1];
            r_sh_btn[i][10] <= w_act[6*i+2];
            r_sh_btn[i][11] <= w_act[6*i+3];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_new_btn = '0;
    w_new_six = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (r_sh_pres[i]) begin
        w_new_six[i] = r_sh_six[i];
        w_new_btn[i] = r_sh_six[i] ? r_sh_btn[i]
                                   : {4'b0, r_sh_btn[i][7:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buttons    <= '0;
      present    <= '0;
      six_btn    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_commit;
      if (w_commit) begin
        buttons <= w_new_btn;
        present <= r_sh_pres;
        six_btn <= w_new_six;
      end
    end
  end

`ifdef PAD_EDGE_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed  <= '0;
      released <= '0;
    end else if (w_commit) begin
      pressed  <= w_new_btn & ~buttons;
      released <= ~w_new_btn & buttons;
    end else begin
      pressed  <= '0;
      released <= '0;
    end
  end
`else
  assign pressed  = '0;
  assign released = '0;
`endif

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// tb_genesis_pad_scanner: directed bench with behavioural 3/6-button pad
// models driven from the shared select line.
module tb_genesis_pad_scanner;

  localparam int NP = 2;
  localparam int CD = 4;
  localparam int FP = 9;

  logic            clk;
  logic            reset;
  logic [6*NP-1:0] pad_data;
  logic            select;
  logic [12*NP-1:0] buttons;
  logic [NP-1:0]   present;
  logic [NP-1:0]   six_btn;
  logic            frame_done;
  logic [12*NP-1:0] pressed;
  logic [12*NP-1:0] released;

  int vectors = 0;
  int miscompares = 0;

  logic        override;
  int          type0, type1;
  logic [11:0] btn0, btn1;
  int          hrun = 0;
  int          lowcnt = 0;

  genesis_pad_scanner #(
    .NUM_PADS(NP), .CLK_DIV(CD), .FRAME_PHASES(FP)
  ) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data), .select(select),
    .buttons(buttons), .present(present), .six_btn(six_btn),
    .frame_done(frame_done), .pressed(pressed), .released(released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // select high for a long stretch resets a 6-button pad's pulse counter
  always @(posedge clk) hrun = select ? hrun + 1 : 0;
  always @(negedge select) lowcnt = (hrun >= 6) ? 1 : lowcnt + 1;

  // type: 0 unplugged, 1 three-button, 2 six-button; returns active-low pins
  function automatic logic [5:0] pins(input int t, input logic [11:0] b,
                                      input logic s, input int lc);
    logic [5:0] a;
    if (t == 0) return 6'h3F;
    if (s) begin
      if (t == 2 && lc == 3) a = {b[6], b[5], b[11], b[10], b[9], b[8]};
      else a = {b[6], b[5], b[3], b[2], b[1], b[0]};
    end else begin
      if (t == 2 && lc == 3) a = {b[7], b[4], 4'b1111};
      else if (t == 2 && lc >= 4) a = {b[7], b[4], 4'b0000};
      else a = {b[7], b[4], 2'b11, b[1], b[0]};
    end
    return ~a;
  endfunction

  always @* begin
    if (override) pad_data = '0;
    else pad_data = {pins(type1, btn1, select, lowcnt),
                     pins(type0, btn0, select, lowcnt)};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < budget);
    chk("fd_seen", 32'(frame_done), 32'd1);
  endtask

`ifdef PAD_EDGE_DETECT_EN
  localparam logic [31:0] EXP_ALL = 32'hFFFFFF;
  localparam logic [31:0] EXP_ST  = 32'h000080;
`else
  localparam logic [31:0] EXP_ALL = 32'h0;
  localparam logic [31:0] EXP_ST  = 32'h0;
`endif

  localparam logic [35:0] SEL_SEQ = 36'hFF0F0F0F0;

  initial begin
    int n;
    int fds;
    override = 1'b1;
    type0 = 0; type1 = 0;
    btn0 = '0; btn1 = '0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_select", 32'(select), 32'd1);
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_present", 32'(present), 32'd0);
    chk("rst_six", 32'(six_btn), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_released", 32'(released), 32'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    wait_fd(100, n);
    chk("first_fd_latency", 32'(n), 32'd32);
    chk("alllow_buttons", 32'(buttons), 32'hFFFFFF);
    chk("alllow_present", 32'(present), 32'h3);
    chk("alllow_six", 32'(six_btn), 32'h3);
    chk("alllow_pressed", 32'(pressed), EXP_ALL);

    fds = 0;
    for (int i = 0; i < 36; i++) begin
      chk("select_seq", 32'(select), 32'(SEL_SEQ[35-i]));
      if (i > 0 && frame_done) fds++;
      @(negedge clk);
    end
    chk("fd_width", 32'(fds), 32'd0);
    chk("fd_period", 32'(frame_done), 32'd1);

    override = 1'b0;
    type0 = 1; btn0 = 12'h011;
    type1 = 2; btn1 = 12'h840;
    wait_fd(100, n);
    wait_fd(100, n);
    chk("pad0_3btn", 32'(buttons[11:0]), 32'h011);
    chk("pad1_6btn", 32'(buttons[23:12]), 32'h840);
    chk("present_both", 32'(present), 32'h3);
    chk("six_mix", 32'(six_btn), 32'h2);

    type0 = 0;
    wait_fd(100, n);
    wait_fd(100, n);
    chk("unplug_present", 32'(present), 32'h2);
    chk("unplug_buttons", 32'(buttons), 32'h840000);
    chk("unplug_six", 32'(six_btn), 32'h2);

    type0 = 1; btn0 = 12'h000;
    wait_fd(100, n);
    wait_fd(100, n);
    chk("idle_buttons", 32'(buttons), 32'h840000);
    chk("idle_pressed", 32'(pressed), 32'h0);
    btn0 = 12'h080;
    wait_fd(100, n);
    chk("frameN_buttons", 32'(buttons), 32'h840080);
    chk("frameN_pressed", 32'(pressed), EXP_ST);
    chk("frameN_released", 32'(released), 32'h0);
    @(negedge clk);
    chk("pressed_width", 32'(pressed), 32'h0);
    wait_fd(100, n);
    chk("frameN1_pressed", 32'(pressed), 32'h0);
    chk("frameN1_released", 32'(released), 32'h0);
    btn0 = 12'h000;
    wait_fd(100, n);
    chk("frameN2_buttons", 32'(buttons), 32'h840000);
    chk("frameN2_released", 32'(released), EXP_ST);
    chk("frameN2_pressed", 32'(pressed), 32'h0);
    @(negedge clk);
    chk("released_width", 32'(released), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
